// File: rtl/uop_retire_counter.sv
// Retired-uop block counter: groups sequential uops into blocks of halfwords.
// Optional MURE_PRIV_SPLIT_EN closes a block whenever the uop privilege changes.
package mure_pkg;
    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 32;
    localparam int ITYPE_LEN   = 3;
    localparam int PRIV_LEN    = 2;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD  = 3'd0,
        EXC  = 3'd1,
        INT  = 3'd2,
        ERET = 3'd3,
        NTB  = 3'd4,
        TB   = 3'd5,
        JMP  = 3'd6,
        RES  = 3'd7
    } itype_e;

    typedef enum logic {IDLE, COUNT} state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        itype_e              itype;
        logic                compressed;
        logic [PRIV_LEN-1:0] priv;
    } uop_entry_s;
endpackage

module uop_retire_counter
    import mure_pkg::*;
#(
    parameter int                     IRETIRE_LEN = mure_pkg::IRETIRE_LEN,
    parameter logic [IRETIRE_LEN-1:0] SAT_THRESH  =
        {IRETIRE_LEN{1'b1}} - IRETIRE_LEN'(3)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   uop_valid_i,
    input  uop_entry_s             uop_i,
    output logic                   uop_ready_o,
    output logic                   blk_valid_o,
    input  logic                   blk_ready_i,
    output logic [IRETIRE_LEN-1:0] blk_iretire_o,
    output itype_e                 blk_itype_o,
    output logic [XLEN-1:0]        blk_iaddr_o,
    output logic [PRIV_LEN-1:0]    blk_priv_o
);
    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        itype_e                 itype;
        logic [XLEN-1:0]        iaddr;
        logic [PRIV_LEN-1:0]    priv;
    } blk_s;

    state_e                 state_q, state_n;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_n;
    logic [XLEN-1:0]        start_pc_q, start_pc_n;
    logic [PRIV_LEN-1:0]    cur_priv_q, cur_priv_n;
    blk_s                   out_q, rec;
    logic                   out_v_q, emit;
    logic                   acc, is_std, split;
    logic [IRETIRE_LEN-1:0] inc;
    logic [IRETIRE_LEN:0]   sum;
`ifdef MURE_PRIV_SPLIT_EN
    // A priv change on a non-STD uop yields two records in one cycle;
    // the second waits here and input is stalled until it drains.
    blk_s                   pend_q, rec2;
    logic                   pend_v_q, emit2;

    assign uop_ready_o = !(out_v_q && !blk_ready_i) && !pend_v_q;
`else
    assign uop_ready_o = !(out_v_q && !blk_ready_i);
`endif

    assign acc    = uop_valid_i && uop_ready_o && uop_i.valid;
    assign is_std = (uop_i.itype == STD) || (uop_i.itype == RES);
    assign inc    = uop_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign sum    = {1'b0, cnt_q} + {1'b0, inc};

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        start_pc_n = start_pc_q;
        cur_priv_n = cur_priv_q;
        emit       = 1'b0;
        rec        = '0;
        split      = 1'b0;
`ifdef MURE_PRIV_SPLIT_EN
        emit2      = 1'b0;
        rec2       = '0;
        split      = (state_q == COUNT) && (uop_i.priv != cur_priv_q);
`endif
        if (acc) begin
            if (state_q == COUNT && !split) begin
                if (!is_std) begin
                    emit    = 1'b1;
                    rec     = '{sum[IRETIRE_LEN-1:0], uop_i.itype,
                                start_pc_q, cur_priv_q};
                    state_n = IDLE;
                end else if (sum >= {1'b0, SAT_THRESH}) begin
                    emit    = 1'b1;
                    rec     = '{sum[IRETIRE_LEN-1:0], STD,
                                start_pc_q, cur_priv_q};
                    state_n = IDLE;
                end else begin
                    cnt_n = sum[IRETIRE_LEN-1:0];
                end
            end else begin
                if (split) begin
                    emit    = 1'b1;
                    rec     = '{cnt_q, STD, start_pc_q, cur_priv_q};
                    state_n = IDLE;
                end
                if (is_std) begin
                    state_n    = COUNT;
                    cnt_n      = inc;
                    start_pc_n = uop_i.pc;
                    cur_priv_n = uop_i.priv;
                end else if (!split) begin
                    emit = 1'b1;
                    rec  = '{inc, uop_i.itype, uop_i.pc, uop_i.priv};
                end
`ifdef MURE_PRIV_SPLIT_EN
                else begin
                    emit2 = 1'b1;
                    rec2  = '{inc, uop_i.itype, uop_i.pc, uop_i.priv};
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_pc_q <= '0;
            cur_priv_q <= '0;
            out_q      <= '0;
            out_v_q    <= 1'b0;
`ifdef MURE_PRIV_SPLIT_EN
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            start_pc_q <= start_pc_n;
            cur_priv_q <= cur_priv_n;
            if (emit) begin
                out_q   <= rec;
                out_v_q <= 1'b1;
            end
`ifdef MURE_PRIV_SPLIT_EN
            else if (pend_v_q && blk_ready_i) begin
                out_q    <= pend_q;
                pend_v_q <= 1'b0;
            end
`endif
            else if (blk_ready_i) begin
                out_v_q <= 1'b0;
            end
`ifdef MURE_PRIV_SPLIT_EN
            if (emit2) begin
                pend_q   <= rec2;
                pend_v_q <= 1'b1;
            end
`endif
        end
    end

    assign blk_valid_o   = out_v_q;
    assign blk_iretire_o = out_q.iretire;
    assign blk_itype_o   = out_q.itype;
    assign blk_iaddr_o   = out_q.iaddr;
    assign blk_priv_o    = out_q.priv;
endmodule

// File: doc/uop_retire_counter.md
UOP_RETIRE_COUNTER -- requirements
Module: uop_retire_counter

Interface
REQ-001: Parameter IRETIRE_LEN, default mure_pkg::IRETIRE_LEN (32): retired-count width in halfwords.
REQ-002: Parameter SAT_THRESH, default 2**IRETIRE_LEN-4: count at or above which a block is force-closed.
REQ-003: The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004: clk_i  input  1  clock, all state on rising edge.
REQ-005: rst_i  input  1  asynchronous, active-high reset.
REQ-006: uop_valid_i  input  1  upstream uop offered.
REQ-007: uop_i  input  XLEN+7  mure_pkg::uop_entry_s {valid, pc, itype, compressed, priv}.
REQ-008: uop_ready_o  output  1  uop accepted when uop_valid_i && uop_ready_o.
REQ-009: blk_valid_o  output  1  block record valid.
REQ-010: blk_ready_i  input  1  downstream takes block when blk_valid_o && blk_ready_i.
REQ-011: blk_iretire_o  output  IRETIRE_LEN  halfwords retired in block.
REQ-012: blk_itype_o  output  ITYPE_LEN  itype of terminating uop (STD when closed by priv change or saturation).
REQ-013: blk_iaddr_o  output  XLEN  pc of first uop in block.
REQ-014: blk_priv_o  output  PRIV_LEN  priv of block's uops.

Function
REQ-015: Uop size inc SHALL be 1 when compressed=1, else 2.
REQ-016: uop_ready_o SHALL be combinational: !(blk_valid_o && !blk_ready_i).
REQ-017: Accepted uops with uop_i.valid=0 SHALL be discarded, with no state change.
REQ-018: itype RES SHALL be treated as STD.
REQ-019: FSM states SHALL be mure_pkg::state_e IDLE and COUNT.
REQ-020: IDLE, accepted STD uop: cnt<=inc, start_pc<=pc, cur_priv<=priv; go to COUNT.
REQ-021: IDLE, accepted non-STD uop: emit {inc, itype, pc, priv}; stay in IDLE.
REQ-022: COUNT, accepted STD uop with same priv: cnt<=cnt+inc.
REQ-023: COUNT, accepted non-STD uop: emit {cnt+inc, itype, start_pc, cur_priv}; go to IDLE.
REQ-024: COUNT, accepted uop with priv!=cur_priv: emit {cnt, STD, start_pc, cur_priv}; the new uop then follows REQ-020/021 in the same cycle.
REQ-025: COUNT, STD uop where cnt+inc>=SAT_THRESH: emit {cnt+inc, STD, start_pc, cur_priv}; go to IDLE.
REQ-026: Emit SHALL load the single output register, with blk_valid_o=1 in the next cycle (1-cycle latency).
REQ-027: blk_valid_o SHALL clear on handshake when there is no simultaneous emit; handshake plus emit in the same cycle loads the new record with blk_valid_o held at 1.
REQ-028: Block outputs SHALL be stable while blk_valid_o && !blk_ready_i.
REQ-029: uop_valid_i low SHALL leave all state unchanged; no uop SHALL be dropped or double-counted.

Reset
REQ-030: rst_i high SHALL asynchronously force state=IDLE, cnt=0, start_pc=0, cur_priv=0, blk_valid_o=0, and all blk_* outputs=0.
REQ-031: Reset mid-block SHALL discard the partial count with no emit; the first uop after release SHALL be handled as in IDLE.

Configuration
REQ-032: Macro MURE_PRIV_SPLIT_EN defined: REQ-024 active.
REQ-033: MURE_PRIV_SPLIT_EN undefined: priv changes SHALL be ignored for block closure, and blk_priv_o SHALL report the priv of the block's first uop.

Verification
REQ-034: Reset, then STD pc=0x100 c=0, STD 0x104 c=1, TB 0x106 c=0 -> one block {iretire=5, itype=TB, iaddr=0x100}.
REQ-035: IDLE, single EXC pc=0x200 c=1 -> block {1, EXC, 0x200} next cycle; state stays IDLE.
REQ-036: blk_ready_i=0 with block pending, uop_valid_i=1 -> uop_ready_o=0 and outputs frozen; blk_ready_i=1 -> uop accepted the same cycle.
REQ-037: With MURE_PRIV_SPLIT_EN: STD priv=3 pc=0x10, STD priv=0 pc=0x14 -> block {2, STD, 0x10, priv=3}, with a new block starting at 0x14. Without the macro: no emit.
REQ-038: SAT_THRESH=8, four non-compressed STD uops from 0x0 -> block {8, STD, 0x0} after the fourth; state returns to IDLE.
REQ-039: Assert rst_i while in COUNT with cnt=6 -> no emit, blk_valid_o=0; the next STD uop restarts cnt=inc.
